// File: rtl/dragster_spi_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between the power-up configurator (0)
// and the runtime register port (1); returns read data and completion/timeout status.
module dragster_spi_arbiter #(
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] cmd0,
   input  logic [15:0] cmd1,
   input  logic [1:0]  slave0,
   input  logic [1:0]  slave1,
   input  logic        op0,
   input  logic        op1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        spi_enable,
   output logic        spi_start_transaction,
   output logic [15:0] spi_outgoing_data,
   output logic [1:0]  spi_slave,
   output logic        spi_operation,
   input  logic        spi_end_of_transaction,
   input  logic [7:0]  spi_incoming_data
);

   // state | meaning
   // IDLE  | sampling req0/req1, master idle
   // BUSY  | transfer running, waiting for end_of_transaction or timeout
   // DONE  | one-cycle ack/err pulse to the granted requester
   // GAP   | GAP_CYCLES idle cycles so ss_n deasserts between transfers
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_GAP} state_t;

   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
   localparam logic [7:0]  GAP_LIM = 8'(GAP_CYCLES - 1);

   state_t      state_q;
   logic        last_grant_q;
   logic [15:0] tmo_cnt_q;
   logic [15:0] tmo_cnt_d;
   logic [7:0]  gap_cnt_q;
   logic        pick_d;
   logic        eot_seen_d;
   logic        tmo_hit_d;

   logic        ack0_q, ack1_q, err0_q, err1_q, busy_q, en_q, start_q, op_q;
   logic [7:0]  rdata_q;
   logic [15:0] out_data_q;
   logic [1:0]  slave_q;

   assign tmo_cnt_d  = tmo_cnt_q + 16'd1;
   // A zero count marks the first BUSY cycle, where a stale eot level is ignored.
   assign eot_seen_d = spi_end_of_transaction && (tmo_cnt_q != 16'd0);
   assign tmo_hit_d  = (tmo_cnt_d == TMO_LIM);
   assign pick_d     = (req0 && req1) ? ~last_grant_q : req1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         tmo_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata_q      <= '0;
         busy_q       <= 1'b0;
         en_q         <= 1'b0;
         start_q      <= 1'b0;
         out_data_q   <= '0;
         slave_q      <= '0;
         op_q         <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req0 || req1) begin
                  last_grant_q <= pick_d;
                  out_data_q   <= pick_d ? cmd1 : cmd0;
                  slave_q      <= pick_d ? slave1 : slave0;
                  op_q         <= pick_d ? op1 : op0;
                  en_q         <= 1'b1;
                  start_q      <= 1'b1;
                  busy_q       <= 1'b1;
                  tmo_cnt_q    <= '0;
                  state_q      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               tmo_cnt_q <= tmo_cnt_d;
               // eot takes precedence over a timeout on the same edge
               if (eot_seen_d || tmo_hit_d) begin
                  en_q    <= 1'b0;
                  start_q <= 1'b0;
                  rdata_q <= eot_seen_d ? spi_incoming_data : 8'h00;
                  ack0_q  <= ~last_grant_q;
                  ack1_q  <= last_grant_q;
                  err0_q  <= ~eot_seen_d & ~last_grant_q;
                  err1_q  <= ~eot_seen_d & last_grant_q;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               gap_cnt_q <= '0;
               state_q   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_LIM) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ack0                  = ack0_q;
   assign ack1                  = ack1_q;
   assign err0                  = err0_q;
   assign err1                  = err1_q;
   assign rdata                 = rdata_q;
   assign busy                  = busy_q;
   assign spi_enable            = en_q;
   assign spi_start_transaction = start_q;
   assign spi_outgoing_data     = out_data_q;
   assign spi_slave             = slave_q;
   assign spi_operation         = op_q;

endmodule

// File: tb/tb_dragster_spi_arbiter.sv
// Bench for dragster_spi_arbiter: directed vector table, randomized transactions against a
// transaction-level model, plus reset-in-flight and minimum-timeout sequences.
module tb_dragster_spi_arbiter;

   localparam int TMO = 64;
   localparam int GAP = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        req0, req1, op0, op1, eot;
   logic [15:0] cmd0, cmd1;
   logic [1:0]  slave0, slave1;
   logic [7:0]  din;
   logic        ack0, ack1, err0, err1, busy, spi_enable, spi_start, spi_op;
   logic [7:0]  rdata;
   logic [15:0] spi_data;
   logic [1:0]  spi_slave;

   logic        t_req0, t_eot;
   logic [7:0]  t_din;
   logic        t_ack0, t_ack1, t_err0, t_err1, t_busy, t_en, t_start, t_op;
   logic [7:0]  t_rdata;
   logic [15:0] t_data;
   logic [1:0]  t_slave;

   dragster_spi_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
      .slave0(slave0), .slave1(slave1), .op0(op0), .op1(op1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata(rdata), .busy(busy), .spi_enable(spi_enable),
      .spi_start_transaction(spi_start), .spi_outgoing_data(spi_data),
      .spi_slave(spi_slave), .spi_operation(spi_op),
      .spi_end_of_transaction(eot), .spi_incoming_data(din)
   );

   dragster_spi_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)) dut_t (
      .clk(clk), .reset_n(reset_n),
      .req0(t_req0), .req1(1'b0), .cmd0(16'h0a0b), .cmd1(16'h0000),
      .slave0(2'd1), .slave1(2'd0), .op0(1'b0), .op1(1'b0),
      .ack0(t_ack0), .ack1(t_ack1), .err0(t_err0), .err1(t_err1),
      .rdata(t_rdata), .busy(t_busy), .spi_enable(t_en),
      .spi_start_transaction(t_start), .spi_outgoing_data(t_data),
      .spi_slave(t_slave), .spi_operation(t_op),
      .spi_end_of_transaction(t_eot), .spi_incoming_data(t_din)
   );

   int n_cmp = 0;
   int n_err = 0;
   int m_last = 1;

   typedef struct {
      bit          r0, r1;
      logic [15:0] c0, c1;
      logic [1:0]  s0, s1;
      bit          o0, o1;
      int          eot_at;
      logic [7:0]  d;
      int          exp_g;
      logic [7:0]  exp_rd;
      bit          exp_err;
      bit          drop;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion rule: eot counts from BUSY cycle 2 on; without it by cycle TMO the transfer aborts.
   function automatic bit model_tmo(input int eot_at);
      int c;
      c = (eot_at < 2) ? 2 : eot_at;
      return (eot_at == 0) || (c > TMO);
   endfunction

   function automatic int model_done(input int eot_at);
      return model_tmo(eot_at) ? TMO : ((eot_at < 2) ? 2 : eot_at);
   endfunction

   task automatic run_txn(input vec_t v);
      int  cyc;
      bit  seen;
      int  done_cyc;
      done_cyc = model_done(v.eot_at);
      req0 = v.r0; req1 = v.r1;
      cmd0 = v.c0; cmd1 = v.c1;
      slave0 = v.s0; slave1 = v.s1;
      op0 = v.o0; op1 = v.o1;
      eot = 1'b0;
      din = ~v.d;
      tick();
      chk("start_after_req", 32'(spi_start), 32'd1);
      chk("enable_after_req", 32'(spi_enable), 32'd1);
      chk("busy_in_busy", 32'(busy), 32'd1);
      chk("out_data", 32'(spi_data), 32'(v.exp_g == 1 ? v.c1 : v.c0));
      chk("out_slave", 32'(spi_slave), 32'(v.exp_g == 1 ? v.s1 : v.s0));
      chk("out_op", 32'(spi_op), 32'(v.exp_g == 1 ? v.o1 : v.o0));
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc <= TMO + 4) begin
         eot = (v.eot_at != 0) && (cyc >= v.eot_at);
         din = eot ? v.d : ~v.d;
         if (v.drop && cyc == 1) begin
            if (v.exp_g == 1) req1 = 1'b0;
            else req0 = 1'b0;
         end
         tick();
         if (ack0 || ack1) seen = 1'b1;
         else cyc++;
      end
      chk("done_cycle", 32'(cyc), 32'(done_cyc));
      chk("ack0", 32'(ack0), 32'(v.exp_g == 0));
      chk("ack1", 32'(ack1), 32'(v.exp_g == 1));
      chk("err0", 32'(err0), 32'(v.exp_g == 0 && v.exp_err));
      chk("err1", 32'(err1), 32'(v.exp_g == 1 && v.exp_err));
      chk("rdata", 32'(rdata), 32'(v.exp_rd));
      chk("enable_in_done", 32'(spi_enable), 32'd0);
      chk("start_in_done", 32'(spi_start), 32'd0);
      eot = 1'b0;
      if (v.exp_g == 1) req1 = 1'b0;
      else req0 = 1'b0;
      for (int g = 0; g < GAP; g++) begin
         tick();
         chk("busy_in_gap", 32'(busy), 32'd1);
         chk("enable_in_gap", 32'(spi_enable), 32'd0);
         chk("no_ack_in_gap", 32'(ack0 | ack1), 32'd0);
      end
      tick();
      chk("idle_after_gap", 32'(busy), 32'd0);
      chk("rdata_hold", 32'(rdata), 32'(v.exp_rd));
      m_last = v.exp_g;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t rv;
      int   k;
      reset_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; eot = 1'b0; din = 8'h00;
      cmd0 = 16'h0; cmd1 = 16'h0; slave0 = 2'd0; slave1 = 2'd0; op0 = 1'b0; op1 = 1'b0;
      t_req0 = 1'b0; t_eot = 1'b0; t_din = 8'hff;

      //        r0    r1    c0        c1        s0    s1    o0    o1   eot  d      g  rd     err   drop
      vt[0]  = '{1'b1, 1'b0, 16'h3305, 16'h0000, 2'd0, 2'd0, 1'b1, 1'b0, 20, 8'h11, 0, 8'h11, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 16'h0000, 16'h0003, 2'd0, 2'd2, 1'b0, 1'b0,  5, 8'ha5, 1, 8'ha5, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 16'h1111, 16'h2222, 2'd1, 2'd3, 1'b1, 1'b0,  3, 8'h01, 0, 8'h01, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 16'h1111, 16'h2222, 2'd1, 2'd3, 1'b1, 1'b0,  7, 8'h02, 1, 8'h02, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 16'h1111, 16'h2222, 2'd1, 2'd3, 1'b1, 1'b0,  2, 8'h03, 0, 8'h03, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 16'h1111, 16'h2222, 2'd1, 2'd3, 1'b1, 1'b0,  9, 8'h04, 1, 8'h04, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 16'h4455, 16'h0000, 2'd2, 2'd0, 1'b0, 1'b0,  1, 8'h3c, 0, 8'h3c, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 16'h0000, 16'h6677, 2'd0, 2'd1, 1'b0, 1'b1, 64, 8'hc3, 1, 8'hc3, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 16'h8899, 16'h0000, 2'd3, 2'd0, 1'b1, 1'b0, 65, 8'h5e, 0, 8'h00, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 16'h0000, 16'haabb, 2'd0, 2'd2, 1'b0, 1'b0,  4, 8'h77, 1, 8'h77, 1'b0, 1'b1};
      vt[10] = '{1'b1, 1'b1, 16'hccdd, 16'heeff, 2'd1, 2'd2, 1'b0, 1'b1, 10, 8'h9e, 0, 8'h9e, 1'b0, 1'b0};

      tick();
      tick();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_enable", 32'(spi_enable), 32'd0);
      chk("reset_start", 32'(spi_start), 32'd0);
      chk("reset_data", 32'(spi_data), 32'd0);
      chk("reset_rdata", 32'(rdata), 32'd0);
      chk("reset_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) run_txn(vt[i]);

      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(1, 3));
         rv.r0 = k[0];
         rv.r1 = k[1];
         rv.c0 = 16'($urandom);
         rv.c1 = 16'($urandom);
         rv.s0 = 2'($urandom);
         rv.s1 = 2'($urandom);
         rv.o0 = 1'($urandom);
         rv.o1 = 1'($urandom);
         rv.eot_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
         rv.d = 8'($urandom);
         rv.drop = ($urandom_range(0, 3) == 0);
         rv.exp_g = (rv.r0 && rv.r1) ? (1 - m_last) : (rv.r1 ? 1 : 0);
         rv.exp_err = model_tmo(rv.eot_at);
         rv.exp_rd = rv.exp_err ? 8'h00 : rv.d;
         run_txn(rv);
      end

      req0 = 1'b1; req1 = 1'b0; cmd0 = 16'hbeef; slave0 = 2'd3; op0 = 1'b1; eot = 1'b0;
      tick();
      chk("rst_seq_start", 32'(spi_start), 32'd1);
      tick();
      tick();
      reset_n = 1'b0;
      req0 = 1'b0;
      tick();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_enable", 32'(spi_enable), 32'd0);
      chk("midrst_start", 32'(spi_start), 32'd0);
      chk("midrst_data", 32'(spi_data), 32'd0);
      chk("midrst_slave", 32'(spi_slave), 32'd0);
      chk("midrst_op", 32'(spi_op), 32'd0);
      chk("midrst_acks", 32'({ack0, ack1, err0, err1}), 32'd0);
      chk("midrst_rdata", 32'(rdata), 32'd0);
      reset_n = 1'b1;
      m_last = 1;
      tick();
      chk("post_rst_idle", 32'(busy), 32'd0);
      chk("post_rst_no_ack", 32'(ack0 | ack1), 32'd0);
      rv = '{1'b1, 1'b1, 16'h1357, 16'h2468, 2'd1, 2'd2, 1'b1, 1'b0, 6, 8'h42, 0, 8'h42, 1'b0, 1'b0};
      run_txn(rv);

      t_req0 = 1'b1;
      tick();
      chk("tmo_start", 32'(t_start), 32'd1);
      k = 1;
      while (!t_ack0 && k < 40) begin
         tick();
         k++;
      end
      chk("tmo_ack_cycle", 32'(k), 32'd17);
      chk("tmo_ack0", 32'(t_ack0), 32'd1);
      chk("tmo_err0", 32'(t_err0), 32'd1);
      chk("tmo_other", 32'({t_ack1, t_err1}), 32'd0);
      chk("tmo_rdata", 32'(t_rdata), 32'd0);
      chk("tmo_enable_done", 32'(t_en), 32'd0);
      t_req0 = 1'b0;
      tick();
      chk("tmo_ack_pulse", 32'(t_ack0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
